// File: rtl/vert_motion_ctrl_if.sv
// Jump-path signal bundle between keyboard/collision/jump-FSM logic and vert_motion_ctrl.
// Pulses (jump_en, hit_ground) are high for exactly one frame_clk cycle and need no ack.
interface vert_motion_ctrl_if;
  logic [31:0] keycode;
  logic [31:0] jump_y_motion;
  logic [9:0]  ground_y;
  logic        ceiling_hit;
  logic        jump_en;
  logic        hit_ground;
  logic        on_ground;
  logic [9:0]  Mario_Y;
  logic [7:0]  y_velocity;
  logic        fell_out;

  modport master (
    output keycode, jump_y_motion, ground_y, ceiling_hit,
    input  jump_en, hit_ground, on_ground, Mario_Y, y_velocity, fell_out
  );

  modport slave (
    input  keycode, jump_y_motion, ground_y, ceiling_hit,
    output jump_en, hit_ground, on_ground, Mario_Y, y_velocity, fell_out
  );
endinterface

// File: rtl/vert_motion_ctrl.sv
// Vertical motion of Mario: jump key decode, rise integration from the jump FSM,
// gravity fall, landing/ceiling detection and pit-death flag.
module vert_motion_ctrl #(
  parameter int        MARIO_H  = 16,
  parameter int        Y_START  = 100,
  parameter int        GRAVITY  = 1,
  parameter int        MAX_FALL = 8,
  parameter int        Y_MAX    = 479,
  parameter logic [7:0] JUMP_KEY = 8'h1A
) (
  input  logic              Reset,
  input  logic              frame_clk,
  vert_motion_ctrl_if.slave bus,
  output logic [1:0]        o_dbg_state
);

  localparam logic [1:0] S_GROUNDED = 2'd0;
  localparam logic [1:0] S_RISING   = 2'd1;
  localparam logic [1:0] S_FALLING  = 2'd2;

  localparam logic signed [11:0] H12    = 12'(MARIO_H);
  localparam logic signed [11:0] YMAX12 = 12'(Y_MAX);
  localparam logic signed [11:0] GRAV12 = 12'(GRAVITY);
  localparam logic signed [11:0] MAXF12 = 12'(MAX_FALL);

  logic [1:0]        r_state, w_n_state;
  logic [9:0]        r_y, w_n_y;
  logic signed [7:0] r_vel, w_n_vel;
  logic              r_key_prev, r_seen, w_n_seen;
  logic [1:0]        r_wait, w_n_wait;
  logic              r_jump_en, w_n_jump_en;
  logic              r_hit, w_n_hit;
  logic              r_fell, w_n_fell;

  logic              w_key_now, w_edge, w_seen_now;
  logic signed [7:0] w_mot8;
  logic signed [11:0] w_y12, w_gnd12, w_gnd_top, w_gnd_snap;
  logic signed [11:0] w_mot12, w_rise_raw, w_rise, w_vel_inc, w_vel_fall, w_ny;
  logic              w_unused;

  assign w_unused  = ^bus.jump_y_motion[31:8];
  assign w_key_now = (bus.keycode[7:0]   == JUMP_KEY) | (bus.keycode[15:8]  == JUMP_KEY) |
                     (bus.keycode[23:16] == JUMP_KEY) | (bus.keycode[31:24] == JUMP_KEY);
  assign w_edge    = w_key_now & ~r_key_prev;

  assign w_mot8     = bus.jump_y_motion[7:0];
  assign w_mot12    = {{4{w_mot8[7]}}, w_mot8};
  assign w_y12      = $signed({2'b00, r_y});
  assign w_gnd12    = $signed({2'b00, bus.ground_y});
  assign w_gnd_top  = w_gnd12 - H12;
  assign w_gnd_snap = (w_gnd_top < 0) ? '0 : w_gnd_top;
  assign w_rise_raw = w_y12 + w_mot12;
  assign w_rise     = (w_rise_raw < 0) ? '0 : w_rise_raw;
  assign w_vel_inc  = {{4{r_vel[7]}}, r_vel} + GRAV12;
  assign w_vel_fall = (w_vel_inc > MAXF12) ? MAXF12 : w_vel_inc;
  assign w_ny       = w_y12 + w_vel_fall;
  assign w_seen_now = r_seen | w_mot8[7];

  always_comb begin
    w_n_state   = r_state;
    w_n_y       = r_y;
    w_n_vel     = r_vel;
    w_n_seen    = r_seen;
    w_n_wait    = r_wait;
    w_n_jump_en = 1'b0;
    w_n_hit     = 1'b0;
    w_n_fell    = r_fell;
    case (r_state)
      S_GROUNDED: begin
        w_n_vel = '0;
        if (w_gnd_top > w_y12) begin
          w_n_state = S_FALLING;
        end else begin
          w_n_y = w_gnd_snap[9:0];
          if (w_edge) begin
            w_n_jump_en = 1'b1;
            w_n_state   = S_RISING;
            w_n_seen    = 1'b0;
            w_n_wait    = '0;
          end
        end
      end
      S_RISING: begin
        if (bus.ceiling_hit) begin
          w_n_hit   = 1'b1;
          w_n_vel   = '0;
          w_n_state = S_FALLING;
        end else begin
          w_n_vel  = w_mot8;
          w_n_y    = w_rise[9:0];
          w_n_seen = w_seen_now;
          // Rise ends when the jump FSM stops pushing up, or never started within 3 frames.
          if (w_seen_now && !w_mot8[7]) begin
            w_n_vel   = '0;
            w_n_state = S_FALLING;
          end else if (!w_seen_now) begin
            w_n_wait = r_wait + 2'd1;
            if (r_wait == 2'd2) begin
              w_n_vel   = '0;
              w_n_state = S_FALLING;
            end
          end
        end
      end
      S_FALLING: begin
        if (w_ny + H12 >= w_gnd12) begin
          w_n_y     = w_gnd_snap[9:0];
          w_n_vel   = '0;
          w_n_hit   = 1'b1;
          w_n_state = S_GROUNDED;
        end else if (w_ny + H12 > YMAX12) begin
          w_n_fell = 1'b1;
        end else begin
          w_n_y   = w_ny[9:0];
          w_n_vel = w_vel_fall[7:0];
        end
      end
      default: w_n_state = S_FALLING;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_FALLING;
      r_y        <= 10'(Y_START);
      r_vel      <= '0;
      r_key_prev <= 1'b0;
      r_seen     <= 1'b0;
      r_wait     <= '0;
      r_jump_en  <= 1'b0;
      r_hit      <= 1'b0;
      r_fell     <= 1'b0;
    end else begin
      r_state    <= w_n_state;
      r_y        <= w_n_y;
      r_vel      <= w_n_vel;
      r_key_prev <= w_key_now;
      r_seen     <= w_n_seen;
      r_wait     <= w_n_wait;
      r_jump_en  <= w_n_jump_en;
      r_hit      <= w_n_hit;
      r_fell     <= w_n_fell;
    end
  end

  assign bus.jump_en    = r_jump_en;
  assign bus.hit_ground = r_hit;
  assign bus.on_ground  = (r_state == S_GROUNDED);
  assign bus.Mario_Y    = r_y;
  assign bus.y_velocity = r_vel;
  assign bus.fell_out   = r_fell;
  assign o_dbg_state    = r_state;

endmodule
